// File: rtl/decoder_pkg.sv
// Shared decode types: opcode map, mux encodings, the decoded bundle and the pure decode function.
// Field widths live here so decoded_t is one type shared by the queue, its storage and the execute stage.
package decoder_pkg;

  localparam int REG_BITS    = 4;
  localparam int PC_BITS     = 8;
  localparam int INSTR_WIDTH = 4 + 3 * REG_BITS;
  localparam int IMM_BITS    = 2 * REG_BITS;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_BR    = 4'h1,
    OP_CMP   = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_MUL   = 4'h5,
    OP_DIV   = 4'h6,
    OP_LDR   = 4'h7,
    OP_STR   = 4'h8,
    OP_CONST = 4'h9,
    OP_RET   = 4'hF
  } opcode_e;

  localparam logic [1:0] REG_IN_ALU   = 2'b00;
  localparam logic [1:0] REG_IN_MEM   = 2'b01;
  localparam logic [1:0] REG_IN_CONST = 2'b10;

  localparam logic [1:0] ARITH_ADD = 2'b00;
  localparam logic [1:0] ARITH_SUB = 2'b01;
  localparam logic [1:0] ARITH_MUL = 2'b10;
  localparam logic [1:0] ARITH_DIV = 2'b11;

  typedef struct packed {
    logic [REG_BITS-1:0] rd;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rt;
    logic [2:0]          nzp;
    logic [IMM_BITS-1:0] imm;
    logic [PC_BITS-1:0]  pc;
    logic                reg_we;
    logic                mem_re;
    logic                mem_we;
    logic                nzp_we;
    logic [1:0]          reg_in_mux;
    logic [1:0]          alu_arith_mux;
    logic                alu_out_mux;
    logic                pc_mux;
    logic                ret;
    logic                illegal;
  } decoded_t;

  function automatic decoded_t decode_instr(input logic [INSTR_WIDTH-1:0] instr,
                                            input logic [PC_BITS-1:0]     pc);
    decoded_t   d;
    logic [3:0] op;
    d    = '0;
    op   = instr[INSTR_WIDTH-1 -: 4];
    d.rd  = instr[3*REG_BITS-1 -: REG_BITS];
    d.rs  = instr[2*REG_BITS-1 -: REG_BITS];
    d.rt  = instr[REG_BITS-1:0];
    d.nzp = instr[3*REG_BITS-1 -: 3];
    d.imm = instr[IMM_BITS-1:0];
    d.pc  = pc;
    case (op)
      OP_NOP:   ;
      OP_BR:    d.pc_mux = 1'b1;
      OP_CMP:   begin d.alu_out_mux = 1'b1; d.nzp_we = 1'b1; end
      OP_ADD:   begin d.reg_we = 1'b1; d.reg_in_mux = REG_IN_ALU; d.alu_arith_mux = ARITH_ADD; end
      OP_SUB:   begin d.reg_we = 1'b1; d.reg_in_mux = REG_IN_ALU; d.alu_arith_mux = ARITH_SUB; end
      OP_MUL:   begin d.reg_we = 1'b1; d.reg_in_mux = REG_IN_ALU; d.alu_arith_mux = ARITH_MUL; end
      OP_DIV:   begin d.reg_we = 1'b1; d.reg_in_mux = REG_IN_ALU; d.alu_arith_mux = ARITH_DIV; end
      OP_LDR:   begin d.reg_we = 1'b1; d.mem_re = 1'b1; d.reg_in_mux = REG_IN_MEM; end
      OP_STR:   d.mem_we = 1'b1;
      OP_CONST: begin d.reg_we = 1'b1; d.reg_in_mux = REG_IN_CONST; end
      OP_RET:   d.ret = 1'b1;
      default:  d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshakes plus queue status for decode_queue.
interface decode_queue_if #(parameter int DEPTH = 2);
  import decoder_pkg::*;

  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [INSTR_WIDTH-1:0]       in_instruction;
  logic [PC_BITS-1:0]           in_pc;
  logic                         out_valid;
  logic                         out_ready;
  decoded_t                     out_decoded;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         halted;

  modport master (
    output flush, in_valid, in_instruction, in_pc, out_ready,
    input  in_ready, out_valid, out_decoded, count, halted
  );

  modport slave (
    input  flush, in_valid, in_instruction, in_pc, out_ready,
    output in_ready, out_valid, out_decoded, count, halted
  );

endinterface

// File: rtl/decode_fifo.sv
// DEPTH-entry storage of decoded bundles; count-based full/empty so pointer equality is never ambiguous.
module decode_fifo
  import decoder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  decoded_t                   wdata,
  output decoded_t                   rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  decoded_t        mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Data array needs no reset: entries are only observed behind a nonzero count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/decode_queue.sv
// Decodes fetched instructions at push and queues finished bundles for execute; RET closes input until flush.
module decode_queue
  import decoder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  decode_queue_if.slave  bus
);

  logic     full;
  logic     empty;
  logic     halted;
  logic     ready;
  logic     push;
  logic     pop;
  decoded_t dec;
  decoded_t head;

  // Ready is registered state only, so fetch never sees a path from out_ready.
  assign ready = !full && !halted;
  assign push  = bus.in_valid && ready && !bus.flush;
  assign pop   = !empty && bus.out_ready && !bus.flush;
  assign dec   = decode_instr(bus.in_instruction, bus.in_pc);

  decode_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (bus.flush),
    .push  (push),
    .pop   (pop),
    .wdata (dec),
    .rdata (head),
    .count (bus.count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted <= 1'b0;
    end else if (bus.flush) begin
      halted <= 1'b0;
    end else if (push && dec.ret) begin
      halted <= 1'b1;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = !empty;
  assign bus.out_decoded = empty ? '0 : head;
  assign bus.halted      = halted;

endmodule

// File: tb/tb_decode_queue.sv
// Directed vectors with a scoreboard: driver queues hand-computed bundles, a negedge monitor checks every pop.
module tb_decode_queue;
  import decoder_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(2)) bus ();

  decode_queue #(.DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int       checks = 0;
  int       errors = 0;
  int       pops   = 0;
  decoded_t sbq[$];
  decoded_t mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic decoded_t base(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                                    input logic [2:0] nzp, input logic [7:0] imm, input logic [7:0] pc);
    decoded_t d;
    d     = '0;
    d.rd  = rd;
    d.rs  = rs;
    d.rt  = rt;
    d.nzp = nzp;
    d.imm = imm;
    d.pc  = pc;
    return d;
  endfunction

  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready && !bus.flush) begin
      checks++;
      pops++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop got %h want none", bus.out_decoded);
      end else begin
        mon_exp = sbq.pop_front();
        if (bus.out_decoded !== mon_exp) begin
          errors++;
          $display("FAIL pop_data got %h want %h", bus.out_decoded, mon_exp);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] instr, input logic [7:0] pc, input decoded_t exp);
    bit ok;
    ok = 1'b0;
    bus.in_valid       = 1'b1;
    bus.in_instruction = instr;
    bus.in_pc          = pc;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      sbq.push_back(exp);
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL push_timeout got in_ready=0 want 1 for %h", instr);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  decoded_t    e;
  logic [15:0] sins [8];
  decoded_t    sexp [8];
  int          p0;

  initial begin
    bus.flush          = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_instruction = '0;
    bus.in_pc          = '0;
    bus.out_ready      = 1'b0;

    #3;
    chk("reset_count", 32'(bus.count), 0);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_decoded_zero", 32'(bus.out_decoded == '0), 1);
    chk("reset_halted", 32'(bus.halted), 0);
    #9 reset = 1'b1;
    cyc(1);
    chk("ready_after_reset", 32'(bus.in_ready), 1);

    // ADD into an empty queue: visible right after its push edge
    bus.out_ready = 1'b1;
    e = base(4'h1, 4'h2, 4'h3, 3'b000, 8'h23, 8'h04);
    e.reg_we = 1'b1;
    drive(16'h3123, 8'h04, e);
    chk("add_latency_valid", 32'(bus.out_valid), 1);
    cyc(2);
    chk("add_drained", 32'(bus.out_valid), 0);

    // Fill to DEPTH with execute stalled, then offer a third
    bus.out_ready = 1'b0;
    e = base(4'h2, 4'h1, 4'h0, 3'b001, 8'h10, 8'h10);
    e.reg_we = 1'b1; e.mem_re = 1'b1; e.reg_in_mux = 2'b01;
    drive(16'h7210, 8'h10, e);
    e = base(4'h3, 4'h0, 4'h5, 3'b001, 8'h05, 8'h11);
    e.reg_we = 1'b1; e.reg_in_mux = 2'b10;
    drive(16'h9305, 8'h11, e);
    chk("full_count", 32'(bus.count), 2);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b1; bus.in_instruction = 16'h0000; bus.in_pc = 8'h12;
    cyc(3);
    chk("full_hold_count", 32'(bus.count), 2);
    chk("full_hold_ready", 32'(bus.in_ready), 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc(1);
    chk("after_pop_count", 32'(bus.count), 1);
    chk("after_pop_ready", 32'(bus.in_ready), 1);
    cyc(1);
    chk("fill_drained", 32'(bus.count), 0);

    // Back-to-back stream with execute always ready
    sins[0] = 16'h3456; sexp[0] = base(4'h4, 4'h5, 4'h6, 3'b010, 8'h56, 8'h20);
    sexp[0].reg_we = 1'b1;
    sins[1] = 16'h4789; sexp[1] = base(4'h7, 4'h8, 4'h9, 3'b011, 8'h89, 8'h21);
    sexp[1].reg_we = 1'b1; sexp[1].alu_arith_mux = 2'b01;
    sins[2] = 16'h5abc; sexp[2] = base(4'ha, 4'hb, 4'hc, 3'b101, 8'hbc, 8'h22);
    sexp[2].reg_we = 1'b1; sexp[2].alu_arith_mux = 2'b10;
    sins[3] = 16'h6def; sexp[3] = base(4'hd, 4'he, 4'hf, 3'b110, 8'hef, 8'h23);
    sexp[3].reg_we = 1'b1; sexp[3].alu_arith_mux = 2'b11;
    sins[4] = 16'h2012; sexp[4] = base(4'h0, 4'h1, 4'h2, 3'b000, 8'h12, 8'h24);
    sexp[4].alu_out_mux = 1'b1; sexp[4].nzp_we = 1'b1;
    sins[5] = 16'h8345; sexp[5] = base(4'h3, 4'h4, 4'h5, 3'b001, 8'h45, 8'h25);
    sexp[5].mem_we = 1'b1;
    sins[6] = 16'h0000; sexp[6] = base(4'h0, 4'h0, 4'h0, 3'b000, 8'h00, 8'h26);
    sins[7] = 16'h1e00; sexp[7] = base(4'he, 4'h0, 4'h0, 3'b111, 8'h00, 8'h27);
    sexp[7].pc_mux = 1'b1;
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      drive(sins[i], sexp[i].pc, sexp[i]);
      chk("stream_count", 32'(bus.count), 1);
    end
    cyc(2);
    chk("stream_pops", 32'(pops - p0), 8);

    // Illegal opcode flows through without halting
    e = base(4'h0, 4'h0, 4'h0, 3'b000, 8'h00, 8'h30);
    e.illegal = 1'b1;
    drive(16'hb000, 8'h30, e);
    chk("illegal_not_halted", 32'(bus.halted), 0);
    e = base(4'h8, 4'h0, 4'h0, 3'b100, 8'h00, 8'h31);
    e.pc_mux = 1'b1;
    drive(16'h1800, 8'h31, e);
    cyc(2);

    // RET closes input even once drained; flush reopens it
    e = base(4'h0, 4'h0, 4'h0, 3'b000, 8'h00, 8'h40);
    e.ret = 1'b1;
    drive(16'hf000, 8'h40, e);
    cyc(3);
    chk("ret_halted", 32'(bus.halted), 1);
    chk("ret_ready_low", 32'(bus.in_ready), 0);
    chk("ret_drained", 32'(bus.count), 0);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_instruction = 16'h3123; bus.in_pc = 8'h41;
    cyc(1);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_halted", 32'(bus.halted), 0);
    chk("flush_ready", 32'(bus.in_ready), 1);

    // Flush with a full queue beats a same-cycle push and pop
    bus.out_ready = 1'b0;
    e = base(4'h1, 4'h2, 4'h3, 3'b000, 8'h23, 8'h50);
    e.reg_we = 1'b1;
    drive(16'h3123, 8'h50, e);
    e = base(4'h3, 4'h0, 4'h5, 3'b001, 8'h05, 8'h51);
    e.reg_we = 1'b1; e.reg_in_mux = 2'b10;
    drive(16'h9305, 8'h51, e);
    bus.out_ready = 1'b1;
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_instruction = 16'h9305; bus.in_pc = 8'h52;
    cyc(1);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    sbq.delete();
    chk("busy_flush_count", 32'(bus.count), 0);
    chk("busy_flush_valid", 32'(bus.out_valid), 0);

    // Asynchronous reset between edges with two entries queued
    bus.out_ready = 1'b0;
    drive(16'h3123, 8'h60, base(4'h1, 4'h2, 4'h3, 3'b000, 8'h23, 8'h60));
    drive(16'h3123, 8'h61, base(4'h1, 4'h2, 4'h3, 3'b000, 8'h23, 8'h61));
    chk("pre_reset_count", 32'(bus.count), 2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_count", 32'(bus.count), 0);
    chk("async_reset_valid", 32'(bus.out_valid), 0);
    sbq.delete();
    #9 reset = 1'b1;
    cyc(1);
    chk("post_reset_ready", 32'(bus.in_ready), 1);

    chk("scoreboard_empty", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
